// File: rtl/fir_pkg.sv
// fir_pkg: shared width defaults and FSM state type for the FIR stream adapter
package fir_pkg;
  localparam int FIR_IN_WIDTH   = 16;
  localparam int FIR_ACC_WIDTH  = 40;
  localparam int FIR_OUT_WIDTH  = 16;
  localparam int FIR_SHIFT      = 15;
  localparam int FIR_FIFO_DEPTH = 4;
  localparam int FIR_TIMEOUT    = 255;
  typedef enum logic {IDLE, WAIT} fir_state_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: synchronous FIFO with registered occupancy and registered not-full flag
module fir_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             ready
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign push    = wr_en && ready;
  assign pop     = rd_en && !empty;
  assign empty   = count == '0;
  assign rd_data = mem[rd_ptr];
  always_comb count_next = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count_next;
      ready <= count_next != CW'(DEPTH);
    end
  end
endmodule

// File: rtl/fir_stream_adapter.sv
// fir_stream_adapter: buffers samples, issues one at a time to a FIR, scales and holds results
module fir_stream_adapter
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_IN_WIDTH,
  parameter int ACC_WIDTH  = FIR_ACC_WIDTH,
  parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
  parameter int SHIFT      = FIR_SHIFT,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH,
  parameter int TIMEOUT    = FIR_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [IN_WIDTH-1:0]  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [IN_WIDTH-1:0]  filt_data_in,
  output logic                        filt_data_in_valid,
  input  logic signed [ACC_WIDTH-1:0] filt_data_out,
  input  logic                        filt_data_out_valid,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_sat,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        timeout_err,
  input  logic                        clr_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  fir_state_t state;
  logic [CW-1:0] wait_cnt;
  logic [IN_WIDTH-1:0] head;
  logic fifo_empty, pop, ovf;
  logic signed [ACC_WIDTH:0] rounded, shifted;
  logic [ACC_WIDTH-OUT_WIDTH+1:0] hi;
  logic [OUT_WIDTH-1:0] scaled;
  assign pop = state == IDLE && !fifo_empty && (!m_valid || m_ready);
  fir_sample_fifo #(.WIDTH(IN_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (s_valid),
    .wr_data(s_data),
    .rd_en  (pop),
    .rd_data(head),
    .empty  (fifo_empty),
    .ready  (s_ready)
  );
  // Round half up one bit wider than the accumulator, then clamp when the bits above the output sign disagree
  always_comb begin
    rounded = $signed({filt_data_out[ACC_WIDTH-1], filt_data_out} + HALF);
    shifted = rounded >>> SHIFT;
    hi      = shifted[ACC_WIDTH:OUT_WIDTH-1];
    ovf     = !((&hi) || !(|hi));
    scaled  = !ovf ? shifted[OUT_WIDTH-1:0]
            : shifted[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      filt_data_in       <= '0;
      filt_data_in_valid <= 1'b0;
      m_data             <= '0;
      m_sat              <= 1'b0;
      m_valid            <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      filt_data_in_valid <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (clr_err) timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (pop) begin
          filt_data_in       <= head;
          filt_data_in_valid <= 1'b1;
          wait_cnt           <= '0;
          state              <= WAIT;
        end
      end else if (filt_data_out_valid) begin
        m_data  <= scaled;
        m_sat   <= ovf;
        m_valid <= 1'b1;
        state   <= IDLE;
      end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
        timeout_err <= 1'b1;
        state       <= IDLE;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_stream_adapter.sv
// tb_fir_stream_adapter: directed self-checking bench with hand-computed expectations
module tb_fir_stream_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [15:0] filt_data_in;
  logic filt_data_in_valid;
  logic signed [39:0] filt_data_out = '0;
  logic filt_data_out_valid = 1'b0;
  logic [15:0] m_data;
  logic m_sat, m_valid;
  logic m_ready = 1'b1;
  logic timeout_err;
  logic clr_err = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fir_stream_adapter #(.TIMEOUT(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .filt_data_in       (filt_data_in),
    .filt_data_in_valid (filt_data_in_valid),
    .filt_data_out      (filt_data_out),
    .filt_data_out_valid(filt_data_out_valid),
    .m_data             (m_data),
    .m_sat              (m_sat),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .timeout_err        (timeout_err),
    .clr_err            (clr_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] d);
    s_data = d;
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
  endtask
  task automatic expect_issue(input logic [15:0] exp, input int budget);
    int n = 0;
    while (!filt_data_in_valid && n < budget) begin
      tick;
      n++;
    end
    chk("issue_seen", filt_data_in_valid, 1);
    chk("issue_data", filt_data_in, exp);
  endtask
  task automatic return_result(input logic signed [39:0] r, input logic [15:0] exp_d, input logic exp_s);
    filt_data_out = r;
    filt_data_out_valid = 1'b1;
    tick;
    filt_data_out_valid = 1'b0;
    chk("res_valid", m_valid, 1);
    chk("res_data", m_data, exp_d);
    chk("res_sat", m_sat, exp_s);
  endtask
  task automatic run_one(input logic [15:0] d, input logic signed [39:0] r, input logic [15:0] exp_d, input logic exp_s);
    push(d);
    chk("lat_t1_no_issue", filt_data_in_valid, 0);
    tick;
    chk("lat_t2_issue", filt_data_in_valid, 1);
    chk("lat_t2_data", filt_data_in, d);
    return_result(r, exp_d, exp_s);
    chk("strobe_single", filt_data_in_valid, 0);
    tick;
    chk("mvalid_cleared", m_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic ok_a, ok_b;
    tick;
    tick;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fdiv", filt_data_in_valid, 0);
    chk("rst_fdi", filt_data_in, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_s_ready", s_ready, 1);
    run_one(16'd32767, 40'sd226878708, 16'd6924, 1'b0);
    run_one(16'h8001, -40'sd226878708, 16'hE4F4, 1'b0);
    run_one(16'd1, 40'sd1073741824, 16'h7FFF, 1'b1);
    run_one(16'd2, -40'sd1073741824, 16'h8000, 1'b0);
    run_one(16'd3, -40'sd1073774592, 16'h8000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      s_data = 16'(101 + i);
      s_valid = 1'b1;
      tick;
      if (i == 1) begin
        chk("full_issue_valid", filt_data_in_valid, 1);
        chk("full_issue_data", filt_data_in, 101);
      end
    end
    chk("full_s_ready", s_ready, 0);
    s_data = 16'd106;
    tick;
    chk("full_s_ready_held", s_ready, 0);
    chk("full_no_second_issue", filt_data_in_valid, 0);
    return_result(40'sd101 <<< 15, 16'd101, 1'b0);
    expect_issue(16'd102, 4);
    chk("full_s_ready_reopen", s_ready, 1);
    return_result(40'sd102 <<< 15, 16'd102, 1'b0);
    s_valid = 1'b0;
    for (int k = 103; k <= 106; k++) begin
      expect_issue(16'(k), 4);
      return_result(40'(k) <<< 15, 16'(k), 1'b0);
    end
    ok_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (filt_data_in_valid || m_valid) ok_a = 1'b0;
    end
    chk("drained_quiet", ok_a, 1);
    m_ready = 1'b0;
    push(16'd201);
    push(16'd202);
    expect_issue(16'd201, 4);
    return_result(40'sd201 <<< 15, 16'd201, 1'b0);
    ok_a = 1'b1;
    ok_b = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (m_data !== 16'd201 || m_valid !== 1'b1) ok_a = 1'b0;
      if (filt_data_in_valid !== 1'b0) ok_b = 1'b0;
    end
    chk("bp_hold", ok_a, 1);
    chk("bp_no_issue", ok_b, 1);
    m_ready = 1'b1;
    tick;
    chk("bp_handshake_clear", m_valid, 0);
    expect_issue(16'd202, 2);
    return_result(40'sd202 <<< 15, 16'd202, 1'b0);
    tick;
    push(16'd301);
    push(16'd302);
    expect_issue(16'd301, 4);
    ok_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      if (timeout_err !== 1'b0) ok_a = 1'b0;
    end
    chk("to_not_early", ok_a, 1);
    tick;
    chk("to_set", timeout_err, 1);
    chk("to_dropped", m_valid, 0);
    expect_issue(16'd302, 4);
    for (int i = 0; i < 7; i++) tick;
    clr_err = 1'b1;
    tick;
    chk("to_wins_over_clr", timeout_err, 1);
    tick;
    chk("clr_clears", timeout_err, 0);
    clr_err = 1'b0;
    filt_data_out = 40'sd12345678;
    filt_data_out_valid = 1'b1;
    tick;
    filt_data_out_valid = 1'b0;
    chk("idle_result_ignored", m_valid, 0);
    chk("idle_result_no_err", timeout_err, 0);
    push(16'd401);
    expect_issue(16'd401, 4);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_fdiv", filt_data_in_valid, 0);
    chk("mid_rst_fdi", filt_data_in, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    filt_data_out = 40'sd401 <<< 15;
    filt_data_out_valid = 1'b1;
    tick;
    filt_data_out_valid = 1'b0;
    chk("late_result_ignored", m_valid, 0);
    chk("late_s_ready", s_ready, 1);
    tick;
    chk("late_still_quiet", m_valid, 0);
    chk("late_m_data", m_data, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
